stream_mux_rr: RTL and testbench
================================

STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 Parameter WIDTH, default 4: data width per channel in bits, min 1.
REQ-002 Parameter N, default 4: input channel count, 2..16.
REQ-003 Parameter SW, default 2: select/channel-index width, SHALL be >= ceil(log2(N)).
REQ-004 Ports: clk  in  1  sole clock, all state rising-edge.
REQ-005 Ports: reset  in  1  asynchronous, active-high.
REQ-006 Ports: in_data  in  N*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
REQ-007 Ports: in_valid  in  N  per-channel beat valid.
REQ-008 Ports: in_last  in  N  per-channel end-of-packet marker.
REQ-009 Ports: in_ready  out  N  per-channel accept; beat transfers when in_valid[i] & in_ready[i].
REQ-010 Ports: mode  in  1  0 = fixed select, 1 = round-robin.
REQ-011 Ports: Select  in  SW  channel index used in fixed mode.
REQ-012 Ports: out_data  out  WIDTH  registered selected data.
REQ-013 Ports: out_last  out  1  registered in_last of the accepted beat.
REQ-014 Ports: out_chan  out  SW  registered index of the source channel.
REQ-015 Ports: out_valid  out  1  output beat valid.
REQ-016 Ports: out_ready  in  1  downstream accept; output transfer when out_valid & out_ready.

Function
REQ-017 Output register SHALL load when (!out_valid | out_ready) and the granted channel has in_valid=1; latency in_valid to out_valid exactly 1 cycle.
REQ-018 At most one in_ready bit SHALL be high per cycle, only for the granted channel, and only when the output register can load.
REQ-019 in_ready SHALL be combinational from grant, in_valid and out_ready, never from in_data.
REQ-020 Fixed mode: grant = Select; Select >= N grants no channel (all in_ready=0).
REQ-021 Round-robin mode: grant = first channel with in_valid=1 searching upward from pointer ptr, wrapping N-1 -> 0.
REQ-022 After a transfer from channel g, ptr SHALL become (g+1) mod N; ptr unchanged when no transfer occurs.
REQ-023 No valid input: out_valid SHALL clear after an output transfer; out_data/out_last/out_chan hold their last values.
REQ-024 Output stalled (out_valid=1, out_ready=0): all output registers hold and all in_ready=0.
REQ-025 out_valid=1 and out_ready=1 in the same cycle as a new grant SHALL give back-to-back transfer with no bubble.
REQ-026 mode or Select change SHALL take effect on the next grant decision and not disturb a beat already in the output register.

Reset
REQ-027 reset=1 SHALL immediately force out_valid=0, out_data=0, out_last=0, out_chan=0, ptr=0, lock state IDLE, independent of clk.
REQ-028 While reset=1 all in_ready SHALL be 0; a beat held at assertion is discarded.
REQ-029 First grant after deassertion SHALL be evaluated at the first rising clk edge with reset=0.

Configuration
REQ-030 Macro STREAM_MUX_PKT_LOCK_EN defined: two-state FSM IDLE/LOCKED; a transfer with in_last=0 enters LOCKED on that channel, a transfer with in_last=1 returns to IDLE.
REQ-031 While LOCKED, grant SHALL stay on the locked channel regardless of mode, Select or other in_valid, and ptr SHALL not advance until the last beat transfers.
REQ-032 Macro undefined: no FSM, arbitration every beat per REQ-020/021; in_last still passed through to out_last.

Verification
REQ-033 Reset mid-transfer: out_valid=1, assert reset between clk edges -> out_valid=0 same instant, ptr=0 after release.
REQ-034 Round-robin, N=4, all in_valid=1 for 8 beats, out_ready=1 -> out_chan sequence 0,1,2,3,0,1,2,3, one beat per cycle.
REQ-035 Fixed mode, Select=2, in_valid=4'b1111, data ch2=4'hA -> only in_ready[2]=1; out_data=4'hA, out_chan=2 one cycle later.
REQ-036 Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data stable, in_ready=4'b0000 for all 3 cycles.
REQ-037 PKT_LOCK_EN: ch1 sends 3 beats (last on 3rd) while ch0/ch2 valid -> out_chan 1,1,1 then 2 (ptr=2); without macro -> 1,2,...
REQ-038 Fixed mode, N=3, Select=3 -> no in_ready asserted, out_valid stays 0.

Source files
------------

// File: rtl/stream_mux_rr.sv
// N-to-1 stream multiplexer with fixed-select or round-robin arbitration and a registered output stage.
// Define STREAM_MUX_PKT_LOCK_EN to hold the grant on one channel until its in_last beat has transferred.
module stream_mux_rr #(
    parameter int WIDTH = 4,
    parameter int N     = 4,
    parameter int SW    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    input  logic [N-1:0]       in_last,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SW-1:0]      Select,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    output logic [SW-1:0]      out_chan,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [SW-1:0]    r_ptr;
    logic [WIDTH-1:0] r_data;
    logic             r_last;
    logic [SW-1:0]    r_chan;
    logic             r_valid;

    logic             w_can_load;
    logic             w_xfer;
    logic             w_ptr_adv;
    logic [N-1:0]     w_rot;
    logic             w_rr_found;
    logic [SW:0]      w_rr_sum;
    logic [SW-1:0]    w_rr_idx;
    logic             w_gnt_vld;
    logic [SW-1:0]    w_gnt;
    logic             w_sel_valid;
    logic [WIDTH-1:0] w_gnt_data;
    logic             w_gnt_last;
    logic [SW:0]      w_inc;
    logic [SW-1:0]    w_ptr_nxt;
    logic             w_locked;
    logic [SW-1:0]    w_lock_chan;

`ifdef STREAM_MUX_PKT_LOCK_EN
    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [SW-1:0] r_lock_chan;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_lock_chan <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer) r_lock_chan <= w_gnt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_xfer) w_state_nxt = w_gnt_last ? ST_IDLE : ST_LOCKED;
    end

    assign w_locked    = (r_state == ST_LOCKED);
    assign w_lock_chan = r_lock_chan;
    // The pointer only moves once the whole packet has gone through.
    assign w_ptr_adv   = w_xfer & w_gnt_last;
`else
    assign w_locked    = 1'b0;
    assign w_lock_chan = '0;
    assign w_ptr_adv   = w_xfer;
`endif

    assign w_can_load = !r_valid || out_ready;

    // Rotate valids so that bit 0 is the channel at the pointer, then take the first set bit.
    assign w_rot = N'({in_valid, in_valid} >> r_ptr);

    always_comb begin
        w_rr_found = 1'b0;
        w_rr_sum   = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_rr_found && w_rot[k]) begin
                w_rr_found = 1'b1;
                w_rr_sum   = {1'b0, r_ptr} + (SW+1)'(k);
            end
        end
        if (w_rr_sum >= (SW+1)'(N)) w_rr_sum = w_rr_sum - (SW+1)'(N);
        w_rr_idx = w_rr_sum[SW-1:0];
    end

    always_comb begin
        w_gnt     = '0;
        w_gnt_vld = 1'b0;
        if (w_locked) begin
            w_gnt     = w_lock_chan;
            w_gnt_vld = 1'b1;
        end else if (mode) begin
            w_gnt     = w_rr_idx;
            w_gnt_vld = w_rr_found;
        end else if ({1'b0, Select} < (SW+1)'(N)) begin
            w_gnt     = Select;
            w_gnt_vld = 1'b1;
        end
    end

    always_comb begin
        w_sel_valid = 1'b0;
        w_gnt_data  = '0;
        w_gnt_last  = 1'b0;
        in_ready    = '0;
        for (int i = 0; i < N; i++) begin
            if (w_gnt_vld && (w_gnt == SW'(i))) begin
                w_sel_valid = in_valid[i];
                w_gnt_data  = in_data[i*WIDTH +: WIDTH];
                w_gnt_last  = in_last[i];
                in_ready[i] = !reset && w_can_load && in_valid[i];
            end
        end
    end

    assign w_xfer    = !reset && w_can_load && w_sel_valid;
    assign w_inc     = {1'b0, w_gnt} + (SW+1)'(1);
    assign w_ptr_nxt = (w_inc >= (SW+1)'(N)) ? '0 : w_inc[SW-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr   <= '0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_chan  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_ptr_adv) r_ptr <= w_ptr_nxt;
            if (w_xfer) begin
                r_data  <= w_gnt_data;
                r_last  <= w_gnt_last;
                r_chan  <= w_gnt;
                r_valid <= 1'b1;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_data;
    assign out_last  = r_last;
    assign out_chan  = r_chan;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a vector table for single-cycle behaviour plus hand sequences
// for asynchronous reset, packet lock and an out-of-range Select on a 3-channel instance.
module tb_stream_mux_rr;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_data;
    logic [3:0]  in_valid, in_last, in_ready;
    logic        mode;
    logic [1:0]  Select;
    logic [3:0]  out_data;
    logic        out_last;
    logic [1:0]  out_chan;
    logic        out_valid;
    logic        out_ready;

    logic [11:0] in_data3;
    logic [2:0]  in_valid3, in_last3, in_ready3;
    logic [1:0]  sel3;
    logic [3:0]  out_data3;
    logic        out_last3;
    logic [1:0]  out_chan3;
    logic        out_valid3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    stream_mux_rr #(.WIDTH(4), .N(4), .SW(2)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .mode(mode), .Select(Select), .out_data(out_data),
        .out_last(out_last), .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
    );

    stream_mux_rr #(.WIDTH(4), .N(3), .SW(2)) dut3 (
        .clk(clk), .reset(reset), .in_data(in_data3), .in_valid(in_valid3), .in_last(in_last3),
        .in_ready(in_ready3), .mode(mode), .Select(sel3), .out_data(out_data3),
        .out_last(out_last3), .out_chan(out_chan3), .out_valid(out_valid3), .out_ready(out_ready)
    );

    typedef struct {
        logic       m;
        logic [1:0] s;
        logic [3:0] iv;
        logic [3:0] il;
        logic       ordy;
        logic [3:0] rdy;
        logic       vld;
        logic [3:0] dat;
        logic [1:0] chn;
        logic       lst;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(logic m, logic [1:0] s, logic [3:0] iv, logic [3:0] il, logic ordy,
                                logic [3:0] rdy, logic vld, logic [3:0] dat, logic [1:0] chn, logic lst);
        vec_t v;
        v.m = m; v.s = s; v.iv = iv; v.il = il; v.ordy = ordy;
        v.rdy = rdy; v.vld = vld; v.dat = dat; v.chn = chn; v.lst = lst;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    logic [1:0] lock_exp[4];
    logic [3:0] lock_il[4];

    initial begin
        // channel data: ch0=5 ch1=6 ch2=A ch3=C ; 3-channel instance: ch0=7 ch1=8 ch2=9
        in_data   = 16'hCA65;
        in_data3  = 12'h987;
        in_valid  = 4'hF;
        in_last   = 4'hF;
        in_valid3 = 3'b000;
        in_last3  = 3'b111;
        sel3      = 2'd3;
        mode      = 1'b1;
        Select    = 2'd0;
        out_ready = 1'b1;
        reset     = 1'b1;

        tbl[0]  = mk(1, 0, 4'hF, 4'hF, 1, 4'b0001, 1, 4'h5, 0, 1);
        tbl[1]  = mk(1, 0, 4'hF, 4'hF, 1, 4'b0010, 1, 4'h6, 1, 1);
        tbl[2]  = mk(1, 0, 4'hF, 4'hF, 1, 4'b0100, 1, 4'hA, 2, 1);
        tbl[3]  = mk(1, 0, 4'hF, 4'hF, 1, 4'b1000, 1, 4'hC, 3, 1);
        tbl[4]  = mk(1, 0, 4'hF, 4'hF, 1, 4'b0001, 1, 4'h5, 0, 1);
        tbl[5]  = mk(1, 0, 4'hF, 4'hF, 1, 4'b0010, 1, 4'h6, 1, 1);
        tbl[6]  = mk(1, 0, 4'hF, 4'hF, 1, 4'b0100, 1, 4'hA, 2, 1);
        tbl[7]  = mk(1, 0, 4'hF, 4'hF, 1, 4'b1000, 1, 4'hC, 3, 1);
        tbl[8]  = mk(1, 0, 4'h0, 4'hF, 1, 4'b0000, 0, 4'hC, 3, 1);
        tbl[9]  = mk(0, 2, 4'hF, 4'hB, 1, 4'b0100, 1, 4'hA, 2, 0);
        tbl[10] = mk(0, 2, 4'hF, 4'hF, 1, 4'b0100, 1, 4'hA, 2, 1);
        tbl[11] = mk(0, 1, 4'hF, 4'hF, 0, 4'b0000, 1, 4'hA, 2, 1);
        tbl[12] = mk(0, 1, 4'hF, 4'hF, 0, 4'b0000, 1, 4'hA, 2, 1);
        tbl[13] = mk(0, 1, 4'hF, 4'hF, 0, 4'b0000, 1, 4'hA, 2, 1);
        tbl[14] = mk(0, 1, 4'hF, 4'hF, 1, 4'b0010, 1, 4'h6, 1, 1);
        tbl[15] = mk(1, 1, 4'hF, 4'hF, 1, 4'b0100, 1, 4'hA, 2, 1);
        tbl[16] = mk(1, 1, 4'h3, 4'hF, 1, 4'b0001, 1, 4'h5, 0, 1);
        tbl[17] = mk(1, 1, 4'h9, 4'hF, 1, 4'b1000, 1, 4'hC, 3, 1);
        tbl[18] = mk(1, 1, 4'h0, 4'hF, 0, 4'b0000, 1, 4'hC, 3, 1);
        tbl[19] = mk(1, 1, 4'h0, 4'hF, 1, 4'b0000, 0, 4'hC, 3, 1);
        tbl[20] = mk(1, 1, 4'h2, 4'hF, 0, 4'b0010, 1, 4'h6, 1, 1);

        // Reset state while clock runs and inputs are valid
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_chan", out_chan, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid3", out_valid3, 0);
        in_valid = 4'h0;
        #10 reset = 1'b0;
        @(posedge clk); #1;

        for (int n = 0; n < 21; n++) begin
            mode = tbl[n].m; Select = tbl[n].s; in_valid = tbl[n].iv;
            in_last = tbl[n].il; out_ready = tbl[n].ordy;
            #3;
            chk($sformatf("v%0d_in_ready", n), in_ready, tbl[n].rdy);
            @(posedge clk); #1;
            chk($sformatf("v%0d_out_valid", n), out_valid, tbl[n].vld);
            chk($sformatf("v%0d_out_data", n), out_data, tbl[n].dat);
            chk($sformatf("v%0d_out_chan", n), out_chan, tbl[n].chn);
            chk($sformatf("v%0d_out_last", n), out_last, tbl[n].lst);
        end

        // Asynchronous reset while a beat is held in the output register
        in_valid = 4'h0; out_ready = 1'b0;
        #3 reset = 1'b1;
        #1;
        chk("amid_out_valid", out_valid, 0);
        chk("amid_out_data", out_data, 0);
        chk("amid_out_chan", out_chan, 0);
        in_valid = 4'hF; out_ready = 1'b1;
        #1 chk("amid_in_ready", in_ready, 0);
        @(posedge clk); #1;
        chk("amid_hold_valid", out_valid, 0);
        reset = 1'b0; mode = 1'b1; in_last = 4'hF;
        #3 chk("post_rst_ready", in_ready, 4'b0001);
        @(posedge clk); #1;
        chk("post_rst_chan", out_chan, 0);
        chk("post_rst_valid", out_valid, 1);

        // Packet from ch1 with ch0/ch2 also valid; pointer now at 1
        lock_il[0] = 4'b0000; lock_il[1] = 4'b0000; lock_il[2] = 4'b0010; lock_il[3] = 4'b0111;
`ifdef STREAM_MUX_PKT_LOCK_EN
        lock_exp[0] = 2'd1; lock_exp[1] = 2'd1; lock_exp[2] = 2'd1; lock_exp[3] = 2'd2;
`else
        lock_exp[0] = 2'd1; lock_exp[1] = 2'd2; lock_exp[2] = 2'd0; lock_exp[3] = 2'd1;
`endif
        in_valid = 4'b0111;
        for (int b = 0; b < 4; b++) begin
            in_last = lock_il[b];
            @(posedge clk); #1;
            chk($sformatf("pkt_beat%0d_chan", b), out_chan, lock_exp[b]);
        end

        // 3-channel instance: Select beyond N grants nothing
        in_valid = 4'h0; mode = 1'b0; in_valid3 = 3'b111;
        for (int c = 0; c < 2; c++) begin
            #3 chk($sformatf("n3_sel3_ready%0d", c), in_ready3, 0);
            @(posedge clk); #1;
            chk($sformatf("n3_sel3_valid%0d", c), out_valid3, 0);
        end
        sel3 = 2'd1;
        #3 chk("n3_sel1_ready", in_ready3, 3'b010);
        @(posedge clk); #1;
        chk("n3_sel1_valid", out_valid3, 1);
        chk("n3_sel1_chan", out_chan3, 1);
        chk("n3_sel1_data", out_data3, 4'h8);
        chk("n3_sel1_last", out_last3, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
